// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// default data width and the doubleword alignment rule.
package unidade_acesso_memoria_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERRO = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 64;
  localparam int ALIGN_BITS = 3;

  // An address is usable when it is doubleword aligned and its index fits in index_w bits.
  function automatic logic addr_ok(input logic [63:0] a, input int index_w);
    return (a[ALIGN_BITS-1:0] == '0) && ((a >> (index_w + ALIGN_BITS)) == 64'd0);
  endfunction

endpackage

// File: rtl/unidade_acesso_memoria_if.sv
// Request/acknowledge bus between the memory-access stage (master) and the data memory (slave).
interface unidade_acesso_memoria_if
  import unidade_acesso_memoria_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_ADDR_W = 10
);

  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/unidade_acesso_memoria_contador.sv
// Clearable/enable counter with a terminal-count output; tc is high on the
// enabled cycle whose edge would bring the count to LIMIT.
module contador_timeout #(
  parameter int LIMIT = 15,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && !tc)
      count <= count + WIDTH'(1);
  end

  assign tc = enable && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/unidade_acesso_memoria.sv
// Memory-access stage: validates the effective address and runs a single
// doubleword load or store over the req/ack bus, with an ack timeout.
module unidade_acesso_memoria
  import unidade_acesso_memoria_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_ADDR_W = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                we,
  input  logic [63:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  unidade_acesso_memoria_if.master mem
);

  state_t state;
  logic   range_err;
  logic   timeout_hit;

  contador_timeout #(
    .LIMIT (TIMEOUT)
  ) u_contador (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .enable ((state == REQ) && !range_err && !mem.mem_ack),
    .tc     (timeout_hit)
  );

  // A bad address still spends one REQ cycle (with mem_req low) so that
  // the error pulse lands in the same cycle as a zero-wait completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      range_err     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= REQ;
            busy          <= 1'b1;
            range_err     <= !addr_ok(addr, MEM_ADDR_W);
            mem.mem_req   <= addr_ok(addr, MEM_ADDR_W);
            mem.mem_we    <= we && addr_ok(addr, MEM_ADDR_W);
            mem.mem_addr  <= addr[MEM_ADDR_W+ALIGN_BITS-1:ALIGN_BITS];
            mem.mem_wdata <= wdata;
          end
        end
        REQ: begin
          if (range_err) begin
            state <= ERRO;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (mem.mem_ack) begin
            if (!mem.mem_we)
              rdata <= mem.mem_rdata;
            state       <= DONE;
            done        <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else if (timeout_hit) begin
            state       <= ERRO;
            done        <= 1'b1;
            err         <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end
        end
        DONE, ERRO: begin
          state     <= IDLE;
          busy      <= 1'b0;
          range_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Self-checking bench for unidade_acesso_memoria: directed cases followed by
// random transactions compared against a transaction-level reference model.
module tb_unidade_acesso_memoria;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;

  unidade_acesso_memoria_if #(.DATA_W(64), .MEM_ADDR_W(10)) mem_if ();

  unidade_acesso_memoria #(
    .DATA_W     (64),
    .MEM_ADDR_W (10),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  logic [63:0] mem     [1024];
  logic [63:0] ref_mem [1024];
  logic [63:0] ref_rdata;

  int total;
  int passed;

  int          obs_done;
  int          obs_err;
  int          obs_reqc;
  int          obs_rises;
  int          obs_unstable;
  int          obs_busy_after;
  logic [63:0] obs_rdata;
  logic [9:0]  obs_addr0;
  logic        obs_we0;
  logic [63:0] obs_wdata0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one transaction; memory acks in cycle delay+1; start stays high
  // (addr=8) for extra_start cycles after acceptance.
  task automatic applyStimulus(input logic we_i, input logic [63:0] addr_i,
                               input logic [63:0] wdata_i, input int delay,
                               input int extra_start);
    logic prev_req;
    obs_done = -1; obs_err = 0; obs_reqc = 0; obs_rises = 0;
    obs_unstable = 0; obs_busy_after = -1; obs_rdata = '0;
    obs_addr0 = '0; obs_we0 = 1'b0; obs_wdata0 = '0;
    prev_req = 1'b0;
    start = 1'b1; we = we_i; addr = addr_i; wdata = wdata_i;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc <= extra_start) begin
        start = 1'b1;
        addr  = 64'd8;
      end else begin
        start = 1'b0;
      end
      if (mem_if.mem_req) begin
        obs_reqc++;
        if (!prev_req) begin
          obs_rises++;
          obs_addr0  = mem_if.mem_addr;
          obs_we0    = mem_if.mem_we;
          obs_wdata0 = mem_if.mem_wdata;
        end else if (mem_if.mem_addr !== obs_addr0 || mem_if.mem_we !== obs_we0 ||
                     mem_if.mem_wdata !== obs_wdata0) begin
          obs_unstable++;
        end
      end
      prev_req = mem_if.mem_req;
      if (done && obs_done < 0) begin
        obs_done  = cyc;
        obs_err   = int'(err);
        obs_rdata = rdata;
      end
      if (obs_done > 0 && cyc == obs_done + 1)
        obs_busy_after = int'(busy);
      if (mem_if.mem_req && cyc == delay + 1) begin
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = mem[mem_if.mem_addr];
        if (mem_if.mem_we)
          mem[mem_if.mem_addr] = mem_if.mem_wdata;
      end else begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = {$urandom, $urandom};
      end
      if (obs_done > 0 && cyc >= obs_done + 4)
        break;
    end
    mem_if.mem_ack = 1'b0;
    start = 1'b0;
  endtask

  // Reference model: outcome of one transaction from the address rule and ack delay.
  task automatic checkTxn(input string tag, input logic we_i, input logic [63:0] addr_i,
                          input logic [63:0] wdata_i, input int delay);
    logic valid;
    int   idx;
    int   exp_done, exp_err, exp_reqc;
    valid = (addr_i % 8 == 0) && (addr_i < 64'h2000);
    idx   = valid ? int'(addr_i / 8) : 0;
    if (!valid) begin
      exp_done = 2; exp_err = 1; exp_reqc = 0;
    end else if (delay < TIMEOUT) begin
      exp_done = delay + 2; exp_err = 0; exp_reqc = delay + 1;
      if (we_i) ref_mem[idx] = wdata_i;
      else      ref_rdata    = ref_mem[idx];
    end else begin
      exp_done = TIMEOUT + 1; exp_err = 1; exp_reqc = TIMEOUT;
    end
    checkOutput({tag, ".done_cycle"}, obs_done, exp_done);
    checkOutput({tag, ".err"}, obs_err, exp_err);
    checkOutput({tag, ".req_cycles"}, obs_reqc, exp_reqc);
    checkOutput({tag, ".busy_after"}, obs_busy_after, 0);
    checkOutput({tag, ".rdata"}, obs_rdata, ref_rdata);
    if (valid) begin
      checkOutput({tag, ".mem_addr"}, obs_addr0, idx[9:0]);
      checkOutput({tag, ".mem_we"}, obs_we0, we_i);
      checkOutput({tag, ".stable"}, obs_unstable, 0);
      if (we_i) checkOutput({tag, ".mem_wdata"}, obs_wdata0, wdata_i);
      checkOutput({tag, ".mem_word"}, mem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          seen_done;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    int          r_delay;
    total = 0; passed = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[5] = 64'hDEADBEEF; ref_mem[5] = 64'hDEADBEEF;
    ref_rdata = '0;

    rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done_err", {done, err}, 0);
    checkOutput("reset.mem_req_we", {mem_if.mem_req, mem_if.mem_we}, 0);
    checkOutput("reset.mem_addr", mem_if.mem_addr, 0);
    checkOutput("reset.mem_wdata", mem_if.mem_wdata, 0);
    checkOutput("reset.rdata", rdata, 0);

    $display("[TB] stray ack while idle");
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 64'h1234_5678_9ABC_DEF0;
    repeat (2) @(negedge clk);
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("stray.busy_done", {busy, done, mem_if.mem_req}, 0);
    checkOutput("stray.rdata", rdata, 0);

    $display("[TB] directed transactions");
    applyStimulus(1'b0, 64'd40, 64'd0, 0, 0);
    checkTxn("load_ok", 1'b0, 64'd40, 64'd0, 0);
    applyStimulus(1'b1, 64'd16, 64'd99, 3, 0);
    checkTxn("store_wait3", 1'b1, 64'd16, 64'd99, 3);
    applyStimulus(1'b0, 64'd21, 64'd0, 0, 0);
    checkTxn("misaligned", 1'b0, 64'd21, 64'd0, 0);
    applyStimulus(1'b1, 64'h2000, 64'd7, 0, 0);
    checkTxn("out_of_range", 1'b1, 64'h2000, 64'd7, 0);
    applyStimulus(1'b0, 64'd24, 64'd0, 1000, 0);
    checkTxn("timeout", 1'b0, 64'd24, 64'd0, 1000);
    checkOutput("timeout.rises", obs_rises, 1);
    applyStimulus(1'b0, 64'd32, 64'd0, TIMEOUT - 1, 0);
    checkTxn("ack_at_limit", 1'b0, 64'd32, 64'd0, TIMEOUT - 1);
    applyStimulus(1'b0, 64'd48, 64'd0, 0, 2);
    checkTxn("busy_ignore", 1'b0, 64'd48, 64'd0, 0);
    checkOutput("busy_ignore.rises", obs_rises, 1);

    $display("[TB] reset during REQ");
    start = 1'b1; we = 1'b0; addr = 64'd56;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_mid.req_before", mem_if.mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid.req_busy", {mem_if.mem_req, busy}, 0);
    checkOutput("rst_mid.rdata", rdata, 0);
    ref_rdata = '0;
    seen_done = 0;
    repeat (4) begin
      seen_done |= int'(done);
      @(negedge clk);
    end
    checkOutput("rst_mid.no_done", seen_done, 0);

    $display("[TB] random transactions");
    for (int i = 0; i < 40; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_wdata = {$urandom, $urandom};
      r_addr  = 64'($urandom_range(0, 1023)) * 8;
      case ($urandom_range(0, 7))
        0: r_addr = r_addr + 64'($urandom_range(1, 7));
        1: r_addr = r_addr | (64'd1 << $urandom_range(13, 63));
        default: ;
      endcase
      r_delay = ($urandom_range(0, 5) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT + 2));
      applyStimulus(r_we, r_addr, r_wdata, r_delay, 0);
      checkTxn($sformatf("rnd%0d", i), r_we, r_addr, r_wdata, r_delay);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
